// File: rtl/l2_req_scheduler_if.sv
// Bundles the three requester channels and the shared L2 port of l2_req_scheduler.
// slave is the scheduler's view; master is the surrounding caches/prefetcher/L2 view.
interface l2_req_scheduler_if;
    logic         i_pmem_read;
    logic         i_pmem_write;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_wdata;
    logic         i_pmem_resp;
    logic [255:0] i_pmem_rdata;

    logic         lsq_pmem_read;
    logic         lsq_pmem_write;
    logic [31:0]  lsq_pmem_address;
    logic [255:0] lsq_pmem_wdata;
    logic         lsq_pmem_resp;
    logic [255:0] lsq_pmem_rdata;

    logic         pref_pmem_read;
    logic [31:0]  pref_pmem_address;
    logic         pref_pmem_resp;
    logic [255:0] pref_pmem_rdata;

    logic         arbiter_idle;

    logic         l2_mem_read;
    logic         l2_mem_write;
    logic [31:0]  l2_mem_address;
    logic [255:0] l2_mem_wdata;
    logic         l2_mem_resp;
    logic [255:0] l2_mem_rdata;

    modport slave (
        input  i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
        output i_pmem_resp, i_pmem_rdata,
        input  lsq_pmem_read, lsq_pmem_write, lsq_pmem_address, lsq_pmem_wdata,
        output lsq_pmem_resp, lsq_pmem_rdata,
        input  pref_pmem_read, pref_pmem_address,
        output pref_pmem_resp, pref_pmem_rdata,
        output arbiter_idle,
        output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
        input  l2_mem_resp, l2_mem_rdata
    );

    modport master (
        output i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
        input  i_pmem_resp, i_pmem_rdata,
        output lsq_pmem_read, lsq_pmem_write, lsq_pmem_address, lsq_pmem_wdata,
        input  lsq_pmem_resp, lsq_pmem_rdata,
        output pref_pmem_read, pref_pmem_address,
        input  pref_pmem_resp, pref_pmem_rdata,
        input  arbiter_idle,
        input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata,
        output l2_mem_resp, l2_mem_rdata
    );
endinterface

// File: rtl/l2_req_scheduler.sv
// Non-preemptive line-granular arbiter sharing one L2 port between I-cache, D-cache and
// next-line prefetcher: D > I > P, with a starvation counter that forces I forward progress.
module l2_req_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    l2_req_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        GRANT_P,
        RELEASE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      lat_address;
    logic [255:0]     lat_wdata;
    logic             lat_write;

    logic i_req;
    logic d_req;
    logic p_req;
    logic starve_hit;
    logic in_grant;

    assign i_req      = bus.i_pmem_read | bus.i_pmem_write;
    assign d_req      = bus.lsq_pmem_read | bus.lsq_pmem_write;
    assign p_req      = bus.pref_pmem_read;
    assign starve_hit = (starve_cnt == CNT_MAX);
    assign in_grant   = (state == GRANT_I) || (state == GRANT_D) || (state == GRANT_P);

    always_comb begin : next_state_logic
        next_state = state;
        unique case (state)
            IDLE: begin
                if (d_req && !(i_req && starve_hit)) begin
                    next_state = GRANT_D;
                end else if (i_req) begin
                    next_state = GRANT_I;
                end else if (p_req) begin
                    next_state = GRANT_P;
                end
            end
            GRANT_I, GRANT_D, GRANT_P: begin
                if (bus.l2_mem_resp) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin : output_logic
        bus.i_pmem_resp     = (state == GRANT_I) && bus.l2_mem_resp;
        bus.lsq_pmem_resp   = (state == GRANT_D) && bus.l2_mem_resp;
        bus.pref_pmem_resp  = (state == GRANT_P) && bus.l2_mem_resp;
        bus.i_pmem_rdata    = bus.l2_mem_rdata;
        bus.lsq_pmem_rdata  = bus.l2_mem_rdata;
        bus.pref_pmem_rdata = bus.l2_mem_rdata;
        bus.arbiter_idle    = !rst && (state == IDLE) && !i_req && !d_req;
        bus.l2_mem_read     = 1'b0;
        bus.l2_mem_write    = 1'b0;
        bus.l2_mem_address  = '0;
        bus.l2_mem_wdata    = '0;
        // The L2 only ever sees the snapshot taken at grant time.
        if (in_grant) begin
            bus.l2_mem_read    = !lat_write;
            bus.l2_mem_write   = lat_write;
            bus.l2_mem_address = lat_address;
            bus.l2_mem_wdata   = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                unique case (next_state)
                    GRANT_D: begin
                        lat_address <= bus.lsq_pmem_address;
                        lat_wdata   <= bus.lsq_pmem_wdata;
                        lat_write   <= bus.lsq_pmem_write;
                        if (i_req && !starve_hit) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                    GRANT_I: begin
                        lat_address <= bus.i_pmem_address;
                        lat_wdata   <= bus.i_pmem_wdata;
                        lat_write   <= bus.i_pmem_write;
                        starve_cnt  <= '0;
                    end
                    GRANT_P: begin
                        lat_address <= bus.pref_pmem_address;
                        lat_wdata   <= '0;
                        lat_write   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_l2_req_scheduler.sv
// Directed and randomized bench for l2_req_scheduler against a transaction-level
// model of the D > I > P priority with I starvation protection.
module tb_l2_req_scheduler;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;

    l2_req_scheduler_if bus ();

    l2_req_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Requester index: 0 = I, 1 = D, 2 = P
    logic         rd   [3];
    logic         wr   [3];
    logic [31:0]  addr [3];
    logic [255:0] wd   [3];
    logic         resp;
    logic [255:0] rdata;

    assign bus.i_pmem_read       = rd[0];
    assign bus.i_pmem_write      = wr[0];
    assign bus.i_pmem_address    = addr[0];
    assign bus.i_pmem_wdata      = wd[0];
    assign bus.lsq_pmem_read     = rd[1];
    assign bus.lsq_pmem_write    = wr[1];
    assign bus.lsq_pmem_address  = addr[1];
    assign bus.lsq_pmem_wdata    = wd[1];
    assign bus.pref_pmem_read    = rd[2];
    assign bus.pref_pmem_address = addr[2];
    assign bus.l2_mem_resp       = resp;
    assign bus.l2_mem_rdata      = rdata;

    int passed = 0;
    int total  = 0;
    int model_cnt = 0;
    int obs_winner = 3;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic set_req(input int who, input logic r, input logic w,
                           input logic [31:0] a, input logic [255:0] d);
        rd[who] = r;
        wr[who] = w;
        addr[who] = a;
        wd[who] = d;
    endtask

    task automatic rand_req(input int who);
        int op;
        op = $urandom_range(0, 2);
        if (who == 2) set_req(2, 1'b1, 1'b0, $urandom() & ~32'h1F, '0);
        else set_req(who, op != 1, op != 0, $urandom() & ~32'h1F, rand_line());
    endtask

    task automatic clear_reqs();
        for (int q = 0; q < 3; q++) set_req(q, 1'b0, 1'b0, '0, '0);
    endtask

    // Called in the IDLE cycle with requests already driven; returns after RELEASE.
    task automatic round(input int lat, input bit mutate, input bit mid_rand,
                         input bit mid_i, input bit spurious);
        int win;
        bit ir, dr, pr, exp_wr;
        logic [31:0]  exp_addr;
        logic [255:0] exp_wd, line;
        logic [2:0]   exp_resp, obs_resp;
        ir = rd[0] | wr[0];
        dr = rd[1] | wr[1];
        pr = rd[2];
        obs_winner = 3;
        @(negedge clk);
        chk("idle_flag", bus.arbiter_idle, !(ir || dr));
        chk("starve_cnt", dut.starve_cnt, model_cnt);
        if (dr && !(ir && model_cnt == LIMIT)) begin
            win = 1;
            if (ir && model_cnt < LIMIT) model_cnt++;
        end else if (ir) begin
            win = 0;
            model_cnt = 0;
        end else if (pr) begin
            win = 2;
        end else begin
            chk("idle_no_req", {bus.l2_mem_read, bus.l2_mem_write}, 2'b00);
            return;
        end
        exp_addr = addr[win];
        exp_wr   = wr[win];
        exp_wd   = wd[win];
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0 && mutate) addr[win] = addr[win] + 32'h40;
            if (k == 0 && mid_i) set_req(0, 1'b1, 1'b0, 32'h180, '0);
            if (k == 0 && mid_rand)
                for (int q = 0; q < 3; q++)
                    if (!(rd[q] | wr[q]) && $urandom_range(0, 3) == 0) rand_req(q);
            line  = rand_line();
            resp  = (k == lat);
            rdata = line;
            @(negedge clk);
            chk("l2_read", bus.l2_mem_read, !exp_wr);
            chk("l2_write", bus.l2_mem_write, exp_wr);
            chk("l2_addr", bus.l2_mem_address, exp_addr);
            if (exp_wr) chk("l2_wdata", bus.l2_mem_wdata, exp_wd);
            exp_resp = (k == lat) ? (3'b001 << win) : 3'b000;
            obs_resp = {bus.pref_pmem_resp, bus.lsq_pmem_resp, bus.i_pmem_resp};
            chk("resp_route", obs_resp, exp_resp);
            if (k == lat) begin
                chk("rdata_fanout", {bus.i_pmem_rdata ^ line, bus.lsq_pmem_rdata ^ line,
                                     bus.pref_pmem_rdata ^ line}, '0);
                if (obs_resp[0]) obs_winner = 0;
                else if (obs_resp[1]) obs_winner = 1;
                else if (obs_resp[2]) obs_winner = 2;
            end
        end
        @(posedge clk); #1;
        resp  = spurious;
        rdata = rand_line();
        @(negedge clk);
        chk("rel_l2_rw", {bus.l2_mem_read, bus.l2_mem_write}, 2'b00);
        chk("rel_l2_addr", bus.l2_mem_address, '0);
        chk("rel_resp", {bus.pref_pmem_resp, bus.lsq_pmem_resp, bus.i_pmem_resp}, 3'b000);
        chk("rel_idle", bus.arbiter_idle, 1'b0);
        resp = 1'b0;
        rd[win] = 1'b0;
        wr[win] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        resp = 1'b0;
        rdata = '0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_idle_flag", bus.arbiter_idle, 1'b0);
        chk("rst_l2_rw", {bus.l2_mem_read, bus.l2_mem_write}, 2'b00);
        chk("rst_resp", {bus.pref_pmem_resp, bus.lsq_pmem_resp, bus.i_pmem_resp}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single I read
        set_req(0, 1'b1, 1'b0, 32'h0000_0060, '0);
        round(5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("i_read_winner", obs_winner, 0);

        // I read and D write together: D first, then I
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0060, '0);
        set_req(1, 1'b0, 1'b1, 32'h0000_0100, {8{32'h1234_5678}});
        round(2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("d_before_i", obs_winner, 1);
        @(posedge clk); #1;
        round(1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("i_after_d", obs_winner, 0);

        // Starvation: I held, D re-requests after every response
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            set_req(0, 1'b1, 1'b0, 32'h0000_0080, '0);
            set_req(1, 1'b1, 1'b0, 32'h0000_0400 + 32'(n) * 32'h40, '0);
            round(1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("starve_seq", obs_winner, (n < LIMIT) ? 1 : 0);
        end
        @(posedge clk); #1;
        clear_reqs();
        round(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Prefetch with I raised mid-transaction
        @(posedge clk); #1;
        set_req(2, 1'b1, 1'b0, 32'h0000_0200, '0);
        round(3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("p_granted", obs_winner, 2);
        @(posedge clk); #1;
        round(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("i_after_p", obs_winner, 0);

        // Address change mid-transaction, plus a stray resp in RELEASE
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 32'h0000_0300, '0);
        round(3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("addr_hold_winner", obs_winner, 1);

        // Reset one cycle into GRANT_D
        @(posedge clk); #1;
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 32'h0000_0500, '0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0600, '0);
        @(negedge clk);
        if (model_cnt < LIMIT) model_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("grant_d_before_rst", bus.l2_mem_address, 32'h0000_0600);
        chk("rst_mid_idle_flag", bus.arbiter_idle, 1'b0);
        chk("rst_mid_cnt", dut.starve_cnt, model_cnt);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_reqs();
        model_cnt = 0;
        resp = 1'b1;
        @(negedge clk);
        chk("post_rst_l2_rw", {bus.l2_mem_read, bus.l2_mem_write}, 2'b00);
        chk("post_rst_resp", {bus.pref_pmem_resp, bus.lsq_pmem_resp, bus.i_pmem_resp}, 3'b000);
        chk("post_rst_cnt", dut.starve_cnt, model_cnt);
        chk("post_rst_idle", bus.arbiter_idle, 1'b1);
        resp = 1'b0;

        // Randomized traffic
        for (int r = 0; r < 300; r++) begin
            @(posedge clk); #1;
            for (int q = 0; q < 3; q++)
                if (!(rd[q] | wr[q]) && $urandom_range(0, 9) < ((q == 1) ? 7 : 4)) rand_req(q);
            round($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                  1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
